// File: rtl/gpio_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cfg_pkg
// Description : Shared types and constants for the pad configuration chain.
// Revision    : 1.0
// ============================================================================
package gpio_cfg_pkg;

    localparam int c_CFG_W_DEFAULT = 13;

    // Bit offsets inside one pad configuration word
    localparam int c_MGMT_EN     = 0;
    localparam int c_OE_N        = 1;
    localparam int c_HLD_OVR     = 2;
    localparam int c_INP_DIS     = 3;
    localparam int c_IB_MODE_SEL = 4;
    localparam int c_ANALOG_EN   = 5;
    localparam int c_ANALOG_SEL  = 6;
    localparam int c_ANALOG_POL  = 7;
    localparam int c_SLOW        = 8;
    localparam int c_VTRIP_SEL   = 9;
    localparam int c_DM_LSB      = 10;
    localparam int c_DM_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_LOAD  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gpio_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cfg_if
// Description : Control, config-fetch and serial-chain signals of the sequencer.
// Revision    : 1.0
// ============================================================================
interface gpio_cfg_if
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS = 38,
    parameter int CFG_W    = c_CFG_W_DEFAULT
);
    localparam int c_ADDR_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic                start;
    logic [c_ADDR_W-1:0] cfg_addr;
    logic [CFG_W-1:0]    cfg_data;
    logic                busy;
    logic                done;
    logic                serial_resetn;
    logic                serial_clock;
    logic                serial_data_out;
    logic                serial_load;

    modport master (
        input  start, cfg_data,
        output cfg_addr, busy, done,
        output serial_resetn, serial_clock, serial_data_out, serial_load
    );

    modport slave (
        output start, cfg_data,
        input  cfg_addr, busy, done,
        input  serial_resetn, serial_clock, serial_data_out, serial_load
    );

endinterface
`default_nettype wire

// File: rtl/gpio_cfg_bitclk.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cfg_bitclk
// Description : Bit-period phase counter, serial clock waveform, bit-end strobe.
// Revision    : 1.0
// ============================================================================
module gpio_cfg_bitclk #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    output logic      o_serial_clock,
    output logic      o_bit_end
);
    localparam int                c_PH_W    = $clog2(CLK_DIV);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_PH_W-1:0] c_PH_HIGH = c_PH_W'(CLK_DIV / 2);

    logic [c_PH_W-1:0] r_phase;
    logic              w_ph_last;

    assign w_ph_last = (r_phase == c_PH_LAST);

    // Phase stays parked at zero while disabled so every bit period starts clean
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_phase <= '0;
        end else if (w_ph_last) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_PH_W'(1);
        end
    end

    assign o_bit_end      = i_en && w_ph_last;
    assign o_serial_clock = i_en && (r_phase >= c_PH_HIGH);

endmodule
`default_nettype wire

// File: rtl/gpio_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gpio_cfg_sequencer
// Description : Clears, serially loads and latches the pad configuration chain.
// Revision    : 1.0
// ============================================================================
module gpio_cfg_sequencer
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS = 38,
    parameter int CFG_W    = c_CFG_W_DEFAULT,
    parameter int CLK_DIV  = 4
) (
    input  wire logic  wb_clk_i,
    input  wire logic  wb_rst_i,
    gpio_cfg_if.master bus
);
    localparam int c_ADDR_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int c_BIT_W  = (CFG_W > 1) ? $clog2(CFG_W) : 1;
    localparam int c_CNT_W  = $clog2(2 * CLK_DIV);

    localparam logic [c_CNT_W-1:0]  c_CLEAR_LAST = c_CNT_W'(2 * CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_LOAD_LAST  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST   = c_BIT_W'(CFG_W - 1);
    localparam logic [c_ADDR_W-1:0] c_PAD_FIRST  = c_ADDR_W'(NUM_PADS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_BIT_W-1:0]  r_bit;
    logic [c_ADDR_W-1:0] r_pad;
    logic [CFG_W-1:0]    r_shift;

    logic w_shift_en;
    logic w_bit_end;
    logic w_serial_clock;
    logic w_last_bit;
    logic w_clear_done;
    logic w_load_done;

    assign w_shift_en   = (r_state == ST_SHIFT);
    assign w_last_bit   = w_bit_end && (r_bit == c_BIT_LAST);
    assign w_clear_done = (r_cnt == c_CLEAR_LAST);
    assign w_load_done  = (r_cnt == c_LOAD_LAST);

    gpio_cfg_bitclk #(
        .CLK_DIV (CLK_DIV)
    ) u_bitclk (
        .clk            (wb_clk_i),
        .rst            (wb_rst_i),
        .i_en           (w_shift_en),
        .o_serial_clock (w_serial_clock),
        .o_bit_end      (w_bit_end)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_CLEAR;
            ST_CLEAR: if (w_clear_done) w_state_next = ST_FETCH;
            ST_FETCH: w_state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (w_last_bit) begin
                    w_state_next = (r_pad != '0) ? ST_FETCH : ST_LOAD;
                end
            end
            ST_LOAD:  if (w_load_done) w_state_next = ST_FIN;
            ST_FIN:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // r_cnt times both the CLEAR and LOAD windows; it rests at zero elsewhere
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_pad   <= '0;
            r_shift <= '0;
        end else begin
            if ((r_state == ST_CLEAR && !w_clear_done) ||
                (r_state == ST_LOAD  && !w_load_done)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            if (!w_shift_en) begin
                r_bit <= '0;
            end else if (w_bit_end) begin
                r_bit <= w_last_bit ? '0 : r_bit + c_BIT_W'(1);
            end

            // r_pad doubles as cfg_addr, so it only moves on entry to FETCH
            if (r_state == ST_CLEAR && w_clear_done) begin
                r_pad <= c_PAD_FIRST;
            end else if (w_last_bit && r_pad != '0) begin
                r_pad <= r_pad - c_ADDR_W'(1);
            end

            if (r_state == ST_FETCH) begin
                r_shift <= bus.cfg_data;
            end else if (w_bit_end) begin
                r_shift <= r_shift << 1;
            end
        end
    end

    assign bus.cfg_addr        = r_pad;
    assign bus.busy            = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign bus.done            = (r_state == ST_FIN);
    assign bus.serial_resetn   = (r_state != ST_CLEAR);
    assign bus.serial_clock    = w_serial_clock;
    assign bus.serial_data_out = w_shift_en && r_shift[CFG_W-1];
    assign bus.serial_load     = (r_state == ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_gpio_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_cfg_sequencer
// Description : Cycle model + chain scoreboard bench for gpio_cfg_sequencer.
// Revision    : 1.0
// ============================================================================
module tb_gpio_cfg_sequencer;
    localparam int SN = 2,  SW = 4,  SD = 4;
    localparam int DN = 38, DW = 13, DD = 4;
    localparam int S_SLOT  = 1 + SW * SD;
    localparam int S_TOTAL = 2 * SD + SN * S_SLOT + SD;
    localparam int D_TOTAL = 2 * DD + DN * (1 + DW * DD) + DD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    gpio_cfg_if #(.NUM_PADS(SN), .CFG_W(SW)) sbus ();
    gpio_cfg_if #(.NUM_PADS(DN), .CFG_W(DW)) dbus ();

    logic [SW-1:0] s_words [SN];
    logic [DW-1:0] d_words [DN];

    assign sbus.cfg_data = s_words[sbus.cfg_addr];
    assign dbus.cfg_data = d_words[dbus.cfg_addr];

    gpio_cfg_sequencer #(.NUM_PADS(SN), .CFG_W(SW), .CLK_DIV(SD)) dut_s (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (sbus.master)
    );

    gpio_cfg_sequencer #(.NUM_PADS(DN), .CFG_W(DW), .CLK_DIV(DD)) dut_d (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (dbus.master)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: m_t = cycles since the accepted start (-1 when not running)
    int m_t   = -1;
    bit m_fin = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_t   <= -1;
            m_fin <= 1'b0;
        end else if (m_t >= 0) begin
            if (m_t == S_TOTAL - 1) begin
                m_t   <= -1;
                m_fin <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end else begin
            m_fin <= 1'b0;
            if (sbus.start && !m_fin) m_t <= 0;
        end
    end

    always @(negedge clk) begin : p_compare
        int   u, pad, s;
        logic e_busy, e_rstn, e_sclk, e_sdo, e_load;
        int   e_addr;
        e_busy = 1'b0; e_rstn = 1'b1; e_sclk = 1'b0; e_sdo = 1'b0; e_load = 1'b0; e_addr = 0;
        if (m_t >= 0) begin
            e_busy = 1'b1;
            if (m_t < 2 * SD) begin
                e_rstn = 1'b0;
            end else if (m_t < 2 * SD + SN * S_SLOT) begin
                u      = m_t - 2 * SD;
                pad    = SN - 1 - u / S_SLOT;
                e_addr = pad;
                if (u % S_SLOT > 0) begin
                    s      = u % S_SLOT - 1;
                    e_sclk = ((s % SD) >= SD / 2);
                    e_sdo  = s_words[pad][SW - 1 - s / SD];
                end
            end else begin
                e_load = 1'b1;
            end
        end
        chk("busy",            64'(sbus.busy),            64'(e_busy));
        chk("done",            64'(sbus.done),            64'(m_fin));
        chk("serial_resetn",   64'(sbus.serial_resetn),   64'(e_rstn));
        chk("serial_clock",    64'(sbus.serial_clock),    64'(e_sclk));
        chk("serial_data_out", 64'(sbus.serial_data_out), 64'(e_sdo));
        chk("serial_load",     64'(sbus.serial_load),     64'(e_load));
        chk("cfg_addr",        64'(sbus.cfg_addr),        64'(e_addr));
    end

    // Chain scoreboards: shift on serial_clock rise, verify each pad at latch
    logic [SN*SW-1:0] s_chain = '0, s_last_chain = '0;
    logic [DN*DW-1:0] d_chain = '0;
    logic s_prev_sclk = 1'b0, s_prev_load = 1'b0, d_prev_sclk = 1'b0, d_prev_load = 1'b0;
    int s_busy_cyc = 0, s_rstn_low = 0, s_load_cyc = 0, s_done_cnt = 0, s_loads = 0;
    int d_busy_cyc = 0, d_done_cnt = 0, d_loads = 0;

    always @(negedge clk) begin
        if (!sbus.serial_resetn) s_chain = '0;
        else if (sbus.serial_clock && !s_prev_sclk)
            s_chain = {s_chain[SN*SW-2:0], sbus.serial_data_out};
        if (sbus.serial_load && !s_prev_load) begin
            s_loads++;
            s_last_chain = s_chain;
            for (int p = 0; p < SN; p++)
                chk("s_latched_word", 64'(s_chain[p*SW +: SW]), 64'(s_words[p]));
        end
        s_busy_cyc += int'(sbus.busy);
        s_rstn_low += int'(!sbus.serial_resetn);
        s_load_cyc += int'(sbus.serial_load);
        s_done_cnt += int'(sbus.done);
        s_prev_sclk = sbus.serial_clock;
        s_prev_load = sbus.serial_load;

        if (!dbus.serial_resetn) d_chain = '0;
        else if (dbus.serial_clock && !d_prev_sclk)
            d_chain = {d_chain[DN*DW-2:0], dbus.serial_data_out};
        if (dbus.serial_load && !d_prev_load) begin
            d_loads++;
            for (int p = 0; p < DN; p++)
                chk("d_latched_word", 64'(d_chain[p*DW +: DW]), 64'(d_words[p]));
        end
        d_busy_cyc += int'(dbus.busy);
        d_done_cnt += int'(dbus.done);
        d_prev_sclk = dbus.serial_clock;
        d_prev_load = dbus.serial_load;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_s();
        sbus.start = 1'b1;
        tick(1);
        sbus.start = 1'b0;
    endtask

    task automatic wait_idle(input bit dflt, input int lim, input string name);
        int k = 0;
        while ((dflt ? (dbus.busy || dbus.done) : (sbus.busy || sbus.done)) && k < lim) begin
            tick(1);
            k++;
        end
        if (k >= lim) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: actual=timeout required=idle within %0d cycles", name, lim);
        end
    endtask

    // One small-config sequence; extra_at>0 re-pulses start that many cycles in
    task automatic run_seq_s(input int extra_at);
        int b, r, l, d, n;
        b = s_busy_cyc; r = s_rstn_low; l = s_load_cyc; d = s_done_cnt; n = s_loads;
        pulse_s();
        if (extra_at > 0) begin
            tick(extra_at - 1);
            pulse_s();
        end
        wait_idle(1'b0, 200, "s_seq_timeout");
        tick(2);
        chk("busy_cycles",   64'(s_busy_cyc - b), 64'd46);
        chk("resetn_low",    64'(s_rstn_low - r), 64'd8);
        chk("load_cycles",   64'(s_load_cyc - l), 64'd4);
        chk("done_pulses",   64'(s_done_cnt - d), 64'd1);
        chk("load_events",   64'(s_loads - n),    64'd1);
        chk("serial_bits",   64'(s_last_chain),   64'hA3);
    endtask

    initial begin : p_main
        int l, d, b;
        sbus.start = 1'b0;
        dbus.start = 1'b0;
        s_words[0] = 4'h3;
        s_words[1] = 4'hA;
        for (int p = 0; p < DN; p++) d_words[p] = DW'($urandom);
        tick(3);
        chk("rst_busy",   64'(sbus.busy),            64'd0);
        chk("rst_resetn", 64'(sbus.serial_resetn),   64'd1);
        chk("rst_sdo",    64'(sbus.serial_data_out), 64'd0);
        chk("rst_addr",   64'(dbus.cfg_addr),        64'd0);
        rst = 1'b0;
        tick(2);

        run_seq_s(0);
        tick(3);
        run_seq_s(10);
        tick(3);

        // Abort during pad 1, bit 2
        pulse_s();
        tick(17);
        chk("pre_abort_busy",   64'(sbus.busy),          64'd1);
        chk("pre_abort_resetn", 64'(sbus.serial_resetn), 64'd1);
        rst = 1'b1;
        tick(1);
        chk("abort_busy",   64'(sbus.busy),            64'd0);
        chk("abort_resetn", 64'(sbus.serial_resetn),   64'd1);
        chk("abort_sclk",   64'(sbus.serial_clock),    64'd0);
        chk("abort_sdo",    64'(sbus.serial_data_out), 64'd0);
        chk("abort_load",   64'(sbus.serial_load),     64'd0);
        chk("abort_addr",   64'(sbus.cfg_addr),        64'd0);
        rst = 1'b0;
        l = s_load_cyc; d = s_done_cnt;
        tick(60);
        chk("abort_no_load", 64'(s_load_cyc - l), 64'd0);
        chk("abort_no_done", 64'(s_done_cnt - d), 64'd0);
        run_seq_s(0);
        tick(2);

        // start coincident with reset is discarded
        d = s_done_cnt;
        sbus.start = 1'b1;
        rst = 1'b1;
        tick(1);
        sbus.start = 1'b0;
        rst = 1'b0;
        chk("start_in_rst_busy", 64'(sbus.busy), 64'd0);
        tick(3);
        chk("start_in_rst_busy2", 64'(sbus.busy), 64'd0);
        chk("start_in_rst_done",  64'(s_done_cnt - d), 64'd0);

        // Random start/reset traffic against the cycle model
        for (int it = 0; it < 8; it++) begin
            wait_idle(1'b0, 200, "rand_idle_timeout");
            for (int p = 0; p < SN; p++) s_words[p] = SW'($urandom);
            repeat (70) begin
                sbus.start = ($urandom_range(0, 7) == 0);
                rst = ($urandom_range(0, 59) == 0);
                tick(1);
            end
            sbus.start = 1'b0;
            rst = 1'b0;
            tick(1);
        end
        wait_idle(1'b0, 200, "rand_idle_timeout");

        // Default-size sweep with random configuration words
        for (int run = 0; run < 2; run++) begin
            for (int p = 0; p < DN; p++) d_words[p] = DW'($urandom);
            b = d_busy_cyc; d = d_done_cnt; l = d_loads;
            dbus.start = 1'b1;
            tick(1);
            dbus.start = 1'b0;
            wait_idle(1'b1, 3000, "d_seq_timeout");
            tick(2);
            chk("d_busy_cycles", 64'(d_busy_cyc - b), 64'(D_TOTAL));
            chk("d_done_pulses", 64'(d_done_cnt - d), 64'd1);
            chk("d_load_events", 64'(d_loads - l),    64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: actual=still running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
